// File: rtl/rr_arbiter.sv
// Round-robin request arbiter with a grant-history mask and a one-hot (or zero) grant.
// Define ARB_FIXED_PRIORITY_EN to remove the mask and get a plain fixed-priority arbiter.
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_GRANT = 4,
  parameter bit REG_OUT   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic                 req_en_i,
  output logic [NUM_GRANT-1:0] grant_o
);

  if (NUM_GRANT != NUM_REQ) begin : g_width_check
    $fatal(1, "rr_arbiter: NUM_GRANT (%0d) must equal NUM_REQ (%0d)", NUM_GRANT, NUM_REQ);
  end

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked_req;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               masked_nz;

  assign masked_req = req_i & ~mask;
  assign masked_nz  = |masked_req;
  assign eligible   = masked_nz ? masked_req : req_i;

  // Highest set index wins, so the ascending scan keeps overwriting with the latest hit.
  always_comb begin
    grant = '0;
    if (req_en_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (eligible[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

`ifdef ARB_FIXED_PRIORITY_EN
  assign mask = '0;
`else
  // An exhausted round restarts with an empty mask; the grant issued that cycle is not recorded.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mask <= '0;
    end else if (req_en_i) begin
      if (masked_nz) begin
        mask <= mask | grant;
      end else begin
        mask <= '0;
      end
    end
  end
`endif

  if (REG_OUT) begin : g_reg_out
    logic [NUM_REQ-1:0] grant_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        grant_q <= '0;
      end else begin
        grant_q <= grant;
      end
    end

    assign grant_o = grant_q;
  end else begin : g_comb_out
    // Keeps the combinational grant silent from reset until the first edge after release.
    logic armed_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        armed_q <= 1'b0;
      end else begin
        armed_q <= 1'b1;
      end
    end

    assign grant_o = armed_q ? grant : '0;
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter: a registered-output instance plus a
// combinational-output instance sharing the same stimulus.
module tb_rr_arbiter;

  logic       clk_i;
  logic       rst_n_i;
  logic [3:0] req_i;
  logic       req_en_i;
  logic [3:0] grant_reg;
  logic [3:0] grant_comb;

  int total = 0;
  int bad   = 0;

  rr_arbiter #(.NUM_REQ(4), .NUM_GRANT(4), .REG_OUT(1'b1)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .req_i    (req_i),
    .req_en_i (req_en_i),
    .grant_o  (grant_reg)
  );

  rr_arbiter #(.NUM_REQ(4), .NUM_GRANT(4), .REG_OUT(1'b0)) dut_comb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .req_i    (req_i),
    .req_en_i (req_en_i),
    .grant_o  (grant_comb)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i  = 1'b0;
    req_i    = 4'b0000;
    req_en_i = 1'b0;
    #12;
    total++;
    if (grant_reg !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_reg: got %b expected %b", grant_reg, 4'b0000);
    end
    req_i    = 4'b1111;
    req_en_i = 1'b1;
    #1;
    total++;
    if (grant_comb !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_comb: got %b expected %b", grant_comb, 4'b0000);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    total++;
    if (grant_comb !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_release_comb: got %b expected %b", grant_comb, 4'b0000);
    end
  endtask

`ifdef ARB_FIXED_PRIORITY_EN
  task automatic test_fixed_priority();
    req_i    = 4'b1111;
    req_en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (grant_reg !== 4'b1000) begin
        bad++;
        $display("[TB] FAIL fixed_1111[%0d]: got %b expected %b", i, grant_reg, 4'b1000);
      end
    end
    req_i = 4'b0110;
    step();
    total++;
    if (grant_reg !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL fixed_0110: got %b expected %b", grant_reg, 4'b0100);
    end
    req_en_i = 1'b0;
    step();
    total++;
    if (grant_reg !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL fixed_disabled: got %b expected %b", grant_reg, 4'b0000);
    end
  endtask
`else
  task automatic test_round_robin();
    logic [3:0] exp_seq [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    req_i    = 4'b1111;
    req_en_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (grant_reg !== exp_seq[i]) begin
        bad++;
        $display("[TB] FAIL rr_1111[%0d]: got %b expected %b", i, grant_reg, exp_seq[i]);
      end
    end
  endtask

  task automatic test_partial_requests();
    logic [3:0] req_seq [6] = '{4'b1001, 4'b1001, 4'b1011, 4'b0001, 4'b0001, 4'b0001};
    logic [3:0] exp_seq [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      req_i = req_seq[i];
      step();
      total++;
      if (grant_reg !== exp_seq[i]) begin
        bad++;
        $display("[TB] FAIL partial[%0d] req=%b: got %b expected %b", i, req_seq[i], grant_reg, exp_seq[i]);
      end
    end
  endtask

  task automatic test_enable();
    req_i    = 4'b1111;
    req_en_i = 1'b1;
    step();
    total++;
    if (grant_reg !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL enable_pre: got %b expected %b", grant_reg, 4'b1000);
    end
    req_en_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (grant_reg !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL enable_off[%0d]: got %b expected %b", i, grant_reg, 4'b0000);
      end
    end
    total++;
    if (grant_comb !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL enable_off_comb: got %b expected %b", grant_comb, 4'b0000);
    end
    req_en_i = 1'b1;
    step();
    total++;
    if (grant_reg !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL enable_resume: got %b expected %b", grant_reg, 4'b0100);
    end
  endtask

  task automatic test_no_request();
    req_i = 4'b0000;
    step();
    total++;
    if (grant_reg !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL no_req: got %b expected %b", grant_reg, 4'b0000);
    end
    req_i = 4'b1111;
    step();
    total++;
    if (grant_reg !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL no_req_mask_cleared: got %b expected %b", grant_reg, 4'b1000);
    end
  endtask

  task automatic test_reset_mid();
    step();
    total++;
    if (grant_reg !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL mid_pre: got %b expected %b", grant_reg, 4'b0100);
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    total++;
    if (grant_reg !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL mid_async_reg: got %b expected %b", grant_reg, 4'b0000);
    end
    total++;
    if (grant_comb !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL mid_async_comb: got %b expected %b", grant_comb, 4'b0000);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();
    total++;
    if (grant_reg !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL mid_after_release: got %b expected %b", grant_reg, 4'b1000);
    end
  endtask

  task automatic test_latency();
    req_i = 4'b0010;
    #1;
    total++;
    if (grant_comb !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL latency_comb: got %b expected %b", grant_comb, 4'b0010);
    end
    total++;
    if (grant_reg !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL latency_reg_hold: got %b expected %b", grant_reg, 4'b1000);
    end
    step();
    total++;
    if (grant_reg !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL latency_reg_edge: got %b expected %b", grant_reg, 4'b0010);
    end
    req_i = 4'b1111;
    #1;
    total++;
    if (grant_comb !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL latency_comb_mask: got %b expected %b", grant_comb, 4'b0100);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef ARB_FIXED_PRIORITY_EN
    test_fixed_priority();
`else
    test_round_robin();
    test_partial_requests();
    test_enable();
    test_no_request();
    test_reset_mid();
    test_latency();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
